// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit in front of data_ram.
// Accepts one request per valid/ready handshake, drives the RAM's word
// address, byte-lane write enables and lane-replicated write data, and
// returns an extracted/extended load result one cycle later.
// Optional feature: define MEM_UNALIGNED_LR_EN to make LWL/LWR/SWL/SWR legal;
// without it those four opcodes report an illegal opcode.
module mem_access_unit #(
  parameter int depth = 65536
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [31:0]               req_addr,
  input  logic [3:0]                req_op,
  input  logic [31:0]               req_wdata,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [31:0]               resp_rdata,
  output logic                      resp_addr_err,
  output logic                      resp_ill_op,
  output logic [31:0]               resp_badvaddr,
  output logic [$clog2(depth)-1:0]  ram_addr,
  output logic [31:0]               ram_din,
  input  logic [31:0]               ram_dout,
  output logic                      ram_en,
  output logic [3:0]                ram_we
);

  localparam int AW = $clog2(depth);

  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LH  = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0010;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1010;
`ifdef MEM_UNALIGNED_LR_EN
  localparam logic [3:0] OP_LWL = 4'b0110;
  localparam logic [3:0] OP_LWR = 4'b0111;
  localparam logic [3:0] OP_SWL = 4'b1110;
  localparam logic [3:0] OP_SWR = 4'b1111;

  // Bits of the old rt value that LWL keeps (the low 3-k bytes).
  function automatic logic [31:0] lwl_keep(input logic [1:0] k);
    case (k)
      2'd0:    lwl_keep = 32'h00FF_FFFF;
      2'd1:    lwl_keep = 32'h0000_FFFF;
      2'd2:    lwl_keep = 32'h0000_00FF;
      2'd3:    lwl_keep = 32'h0000_0000;
      default: lwl_keep = 32'h0000_0000;
    endcase
  endfunction

  // Bits of the old rt value that LWR keeps (the high k bytes).
  function automatic logic [31:0] lwr_keep(input logic [1:0] k);
    case (k)
      2'd0:    lwr_keep = 32'h0000_0000;
      2'd1:    lwr_keep = 32'hFF00_0000;
      2'd2:    lwr_keep = 32'hFFFF_0000;
      2'd3:    lwr_keep = 32'hFFFF_FF00;
      default: lwr_keep = 32'h0000_0000;
    endcase
  endfunction

  // SWL writes lanes 0..k.
  function automatic logic [3:0] swl_lanes(input logic [1:0] k);
    case (k)
      2'd0:    swl_lanes = 4'b0001;
      2'd1:    swl_lanes = 4'b0011;
      2'd2:    swl_lanes = 4'b0111;
      2'd3:    swl_lanes = 4'b1111;
      default: swl_lanes = 4'b0000;
    endcase
  endfunction
`endif

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t      state_r;
  logic        resp_valid_r;
  logic [31:0] resp_rdata_r;
  logic        resp_addr_err_r;
  logic        resp_ill_op_r;
  logic [31:0] resp_badvaddr_r;

  logic        accept_s;
  logic [1:0]  k_s;
  logic [31:0] shifted_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [3:0]  we_s;
  logic [31:0] din_s;
  logic [31:0] rdata_s;
  logic        addr_err_s;
  logic        ill_op_s;

  // A new request can enter whenever the response register is free or is
  // being drained in the same cycle; reset blocks acceptance outright.
  assign req_ready = ~reset & ((state_r == IDLE) | resp_ready);
  assign accept_s  = req_valid & req_ready;

  assign ram_en   = accept_s;
  assign ram_addr = req_addr[AW+1:2];
  assign ram_din  = din_s;
  assign ram_we   = accept_s ? we_s : 4'b0000;

  assign resp_valid    = resp_valid_r;
  assign resp_rdata    = resp_rdata_r;
  assign resp_addr_err = resp_addr_err_r;
  assign resp_ill_op   = resp_ill_op_r;
  assign resp_badvaddr = resp_badvaddr_r;

  // Decode the request: lane enables, lane data, load extraction and errors.
  always_comb begin
    k_s        = req_addr[1:0];
    shifted_s  = ram_dout >> {k_s, 3'b000};
    byte_s     = shifted_s[7:0];
    half_s     = k_s[1] ? ram_dout[31:16] : ram_dout[15:0];
    we_s       = 4'b0000;
    din_s      = req_wdata;
    rdata_s    = 32'h0000_0000;
    addr_err_s = 1'b0;
    ill_op_s   = 1'b0;
    case (req_op)
      OP_LB:  rdata_s = {{24{byte_s[7]}}, byte_s};
      OP_LBU: rdata_s = {24'h00_0000, byte_s};
      OP_LH: begin
        if (k_s[0]) begin
          addr_err_s = 1'b1;
        end else begin
          rdata_s = {{16{half_s[15]}}, half_s};
        end
      end
      OP_LHU: begin
        if (k_s[0]) begin
          addr_err_s = 1'b1;
        end else begin
          rdata_s = {16'h0000, half_s};
        end
      end
      OP_LW: begin
        if (k_s != 2'b00) begin
          addr_err_s = 1'b1;
        end else begin
          rdata_s = ram_dout;
        end
      end
      OP_SB: begin
        we_s  = 4'b0001 << k_s;
        din_s = {4{req_wdata[7:0]}};
      end
      OP_SH: begin
        din_s = {2{req_wdata[15:0]}};
        if (k_s[0]) begin
          addr_err_s = 1'b1;
        end else begin
          we_s = k_s[1] ? 4'b1100 : 4'b0011;
        end
      end
      OP_SW: begin
        if (k_s != 2'b00) begin
          addr_err_s = 1'b1;
        end else begin
          we_s = 4'b1111;
        end
      end
`ifdef MEM_UNALIGNED_LR_EN
      OP_LWL: rdata_s = (ram_dout << {~k_s, 3'b000}) | (req_wdata & lwl_keep(k_s));
      OP_LWR: rdata_s = (ram_dout >> {k_s, 3'b000}) | (req_wdata & lwr_keep(k_s));
      OP_SWL: begin
        we_s  = swl_lanes(k_s);
        din_s = req_wdata >> {~k_s, 3'b000};
      end
      OP_SWR: begin
        we_s  = 4'b1111 << k_s;
        din_s = req_wdata << {k_s, 3'b000};
      end
`endif
      default: ill_op_s = 1'b1;
    endcase
  end

  // Response FSM: capture on accept, release on consume, hold under backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= IDLE;
      resp_valid_r    <= 1'b0;
      resp_rdata_r    <= 32'h0000_0000;
      resp_addr_err_r <= 1'b0;
      resp_ill_op_r   <= 1'b0;
      resp_badvaddr_r <= 32'h0000_0000;
    end else if (accept_s) begin
      state_r         <= RESP;
      resp_valid_r    <= 1'b1;
      resp_rdata_r    <= rdata_s;
      resp_addr_err_r <= addr_err_s;
      resp_ill_op_r   <= ill_op_s;
      resp_badvaddr_r <= addr_err_s ? req_addr : 32'h0000_0000;
    end else if ((state_r == RESP) && resp_ready) begin
      state_r         <= IDLE;
      resp_valid_r    <= 1'b0;
      resp_rdata_r    <= 32'h0000_0000;
      resp_addr_err_r <= 1'b0;
      resp_ill_op_r   <= 1'b0;
      resp_badvaddr_r <= 32'h0000_0000;
    end else begin
      state_r         <= state_r;
      resp_valid_r    <= resp_valid_r;
      resp_rdata_r    <= resp_rdata_r;
      resp_addr_err_r <= resp_addr_err_r;
      resp_ill_op_r   <= resp_ill_op_r;
      resp_badvaddr_r <= resp_badvaddr_r;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised self-checking bench for mem_access_unit with a byte-addressed
// behavioural memory model and a few literal expectations.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [3:0]  req_op;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_addr_err;
  logic        resp_ill_op;
  logic [31:0] resp_badvaddr;
  logic [15:0] ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic        ram_en;
  logic [3:0]  ram_we;

  always #5 clk = ~clk;

  mem_access_unit #(.depth(65536)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_op(req_op), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_addr_err(resp_addr_err), .resp_ill_op(resp_ill_op),
    .resp_badvaddr(resp_badvaddr),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .ram_en(ram_en), .ram_we(ram_we)
  );

`ifdef MEM_UNALIGNED_LR_EN
  localparam bit LR_EN = 1'b1;
`else
  localparam bit LR_EN = 1'b0;
`endif

  // Small RAM aliased on ram_addr[7:0]; the model aliases the same way.
  logic [31:0] ram [0:255];
  logic        mem_init;

  function automatic logic [31:0] seed(input int w);
    logic [31:0] v;
    v = (32'(w) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    if (w == 8) v = 32'h4433_2211;
    return v;
  endfunction

  assign ram_dout = ram[ram_addr[7:0]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= seed(i);
    end else if (ram_en) begin
      for (int l = 0; l < 4; l++)
        if (ram_we[l]) ram[ram_addr[7:0]][8*l +: 8] <= ram_din[8*l +: 8];
    end
  end

  // Behavioural model: memory as bytes, indexed by byte address.
  logic [7:0] mb [0:1023];

  int total = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic model_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rt,
                           output logic [31:0] rdata, output logic aerr, output logic ill,
                           output logic [31:0] bad, output logic [3:0] we, output logic [31:0] din);
    logic [7:0] m [4];
    logic [7:0] r [4];
    logic [7:0] d [4];
    int k;
    k = int'(a[1:0]);
    for (int i = 0; i < 4; i++) begin
      m[i] = mb[{a[9:2], 2'(i)}];
      r[i] = rt[8*i +: 8];
      d[i] = 8'h00;
    end
    rdata = 32'h0; aerr = 1'b0; ill = 1'b0; we = 4'b0000; din = 32'h0;
    case (op)
      4'b0000: rdata = {{24{m[k][7]}}, m[k]};
      4'b0100: rdata = {24'h0, m[k]};
      4'b0001: if (a[0]) aerr = 1'b1; else rdata = {{16{m[k+1][7]}}, m[k+1], m[k]};
      4'b0101: if (a[0]) aerr = 1'b1; else rdata = {16'h0, m[k+1], m[k]};
      4'b0010: if (k != 0) aerr = 1'b1; else rdata = {m[3], m[2], m[1], m[0]};
      4'b0110: if (!LR_EN) ill = 1'b1;
               else for (int i = 0; i < 4; i++) rdata[8*i +: 8] = (i >= 3 - k) ? m[i - (3 - k)] : r[i];
      4'b0111: if (!LR_EN) ill = 1'b1;
               else for (int i = 0; i < 4; i++) rdata[8*i +: 8] = (i <= 3 - k) ? m[i + k] : r[i];
      4'b1000: begin we[k] = 1'b1; din = {4{r[0]}}; end
      4'b1001: if (a[0]) aerr = 1'b1; else begin we[k] = 1'b1; we[k+1] = 1'b1; din = {2{rt[15:0]}}; end
      4'b1010: if (k != 0) aerr = 1'b1; else begin we = 4'b1111; din = rt; end
      4'b1110: if (!LR_EN) ill = 1'b1;
               else for (int i = 0; i < 4; i++) if (i <= k) begin we[i] = 1'b1; din[8*i +: 8] = r[i + 3 - k]; end
      4'b1111: if (!LR_EN) ill = 1'b1;
               else for (int i = 0; i < 4; i++) if (i >= k) begin we[i] = 1'b1; din[8*i +: 8] = r[i - k]; end
      default: ill = 1'b1;
    endcase
    bad = aerr ? a : 32'h0;
    for (int i = 0; i < 4; i++)
      if (we[i]) mb[{a[9:2], 2'(i)}] = din[8*i +: 8];
  endtask

  // Pending response expected from the model.
  logic        pv = 1'b0;
  logic [31:0] p_rdata, p_bad;
  logic        p_aerr, p_ill;
  logic        p_lit_en;
  logic [31:0] p_lit;

  // One cycle: inputs already driven; check outputs, advance the model.
  task automatic step(input logic lit_ld_en, input logic [31:0] lit_ld,
                      input logic lit_st_en, input logic [3:0] lit_we, input logic [31:0] lit_din);
    logic exp_ready, acc;
    logic [31:0] rd, bad, din;
    logic ae, il;
    logic [3:0] we;
    #1;
    exp_ready = !reset && (!pv || resp_ready);
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    acc = req_valid && exp_ready;
    chk("ram_en", 32'(ram_en), 32'(acc));
    chk("resp_valid", 32'(resp_valid), 32'(pv));
    if (pv) begin
      chk("resp_rdata", resp_rdata, p_rdata);
      chk("resp_addr_err", 32'(resp_addr_err), 32'(p_aerr));
      chk("resp_ill_op", 32'(resp_ill_op), 32'(p_ill));
      chk("resp_badvaddr", resp_badvaddr, p_bad);
      if (p_lit_en) chk("lit_rdata", resp_rdata, p_lit);
    end
    we = 4'b0000; rd = 32'h0; bad = 32'h0; din = 32'h0; ae = 1'b0; il = 1'b0;
    if (acc) model_req(req_op, req_addr, req_wdata, rd, ae, il, bad, we, din);
    chk("ram_we", 32'(ram_we), 32'(we));
    if (acc) chk("ram_addr", 32'(ram_addr), 32'(req_addr[17:2]));
    if (acc && we != 4'b0000) chk("ram_din", ram_din, din);
    if (acc && lit_st_en) begin
      chk("lit_we", 32'(ram_we), 32'(lit_we));
      if (lit_we != 4'b0000) chk("lit_din", ram_din, lit_din);
    end
    if (reset) pv = 1'b0;
    else if (acc) begin
      pv = 1'b1; p_rdata = rd; p_aerr = ae; p_ill = il; p_bad = bad;
      p_lit_en = lit_ld_en; p_lit = lit_ld;
    end else if (pv && resp_ready) pv = 1'b0;
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd;
  endtask

  localparam logic [3:0] LEGAL [12] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6,
                                        4'h7, 4'h8, 4'h9, 4'hA, 4'hE, 4'hF};

  initial begin
    for (int w = 0; w < 256; w++)
      for (int i = 0; i < 4; i++) mb[4*w + i] = seed(w)[8*i +: 8];
    reset = 1'b1; mem_init = 1'b1; resp_ready = 1'b1;
    drive(4'hA, 32'h0000_0010, 32'h1234_5678);
    @(negedge clk);
    @(negedge clk);
    // Reset state, with a store presented that must not be written.
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_addr_err", 32'(resp_addr_err), 32'h0);
    chk("rst_resp_ill_op", 32'(resp_ill_op), 32'h0);
    chk("rst_resp_badvaddr", resp_badvaddr, 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_ram_en", 32'(ram_en), 32'h0);
    chk("rst_ram_we", 32'(ram_we), 32'h0);
    reset = 1'b0; mem_init = 1'b0; req_valid = 1'b0;
    @(negedge clk);

    // Directed sequence with hand-computed expectations.
    drive(4'hA, 32'h10, 32'hDEAD_BEEF); step(1'b0, 32'h0, 1'b1, 4'b1111, 32'hDEAD_BEEF);
    drive(4'h2, 32'h10, 32'h0);         step(1'b1, 32'hDEAD_BEEF, 1'b0, 4'b0, 32'h0);
    drive(4'h8, 32'h13, 32'h0000_00AA); step(1'b0, 32'h0, 1'b1, 4'b1000, 32'hAAAA_AAAA);
    drive(4'h0, 32'h13, 32'h0);         step(1'b1, 32'hFFFF_FFAA, 1'b0, 4'b0, 32'h0);
    drive(4'h4, 32'h13, 32'h0);         step(1'b1, 32'h0000_00AA, 1'b0, 4'b0, 32'h0);
    drive(4'h1, 32'h12, 32'h0);         step(1'b1, 32'hFFFF_AAAD, 1'b0, 4'b0, 32'h0);
    drive(4'h1, 32'h11, 32'h0);         step(1'b1, 32'h0, 1'b1, 4'b0000, 32'h0);
    drive(4'h6, 32'h21, 32'hAABB_CCDD); step(1'b1, LR_EN ? 32'h2211_CCDD : 32'h0, 1'b1, 4'b0000, 32'h0);
    drive(4'h7, 32'h21, 32'hAABB_CCDD); step(1'b1, LR_EN ? 32'hAA44_3322 : 32'h0, 1'b0, 4'b0, 32'h0);
    drive(4'hF, 32'h22, 32'hAABB_CCDD); step(1'b0, 32'h0, 1'b1, LR_EN ? 4'b1100 : 4'b0000, 32'hCCDD_0000);
    req_valid = 1'b0;
    step(1'b0, 32'h0, 1'b0, 4'b0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 4'b0, 32'h0);

    // Randomised traffic with backpressure and occasional reset.
    for (int c = 0; c < 4000; c++) begin
      logic [31:0] a;
      logic [3:0]  op;
      op = ($urandom_range(0, 9) < 8) ? LEGAL[$urandom_range(0, 11)] : 4'($urandom_range(0, 15));
      a  = ($urandom_range(0, 9) < 9) ? ($urandom & 32'h0000_00FF) : $urandom;
      drive(op, a, $urandom);
      req_valid  = ($urandom_range(0, 9) < 8);
      resp_ready = ($urandom_range(0, 9) < 6);
      reset      = ($urandom_range(0, 99) < 3);
      step(1'b0, 32'h0, 1'b0, 4'b0, 32'h0);
    end
    reset = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
    step(1'b0, 32'h0, 1'b0, 4'b0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 4'b0, 32'h0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store unit that sits directly upstream of data_ram.
- Takes one load/store request per handshake from the CPU MEM stage and turns it into the RAM's word address, byte-lane write enables and lane-replicated write data.
- Captures the RAM's asynchronous read word and returns an extracted, sign- or zero-extended result one cycle later over a valid/ready response channel.
- Detects misaligned addresses and illegal opcodes.

Parameters:
depth, 65536, word depth of the attached data_ram; ram_addr width is $clog2(depth)

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid & req_ready at the rising edge
req_addr  in  32  byte address
req_op  in  4  operation: LB 0000, LH 0001, LW 0010, LBU 0100, LHU 0101, LWL 0110, LWR 0111, SB 1000, SH 1001, SW 1010, SWL 1110, SWR 1111; all other codes are illegal
req_wdata  in  32  store data; for LWL/LWR, the old rt value to merge with
resp_valid  out  1  response present
resp_ready  in  1  response consumed when resp_valid & resp_ready at the rising edge
resp_rdata  out  32  load result; 0 for stores and for any error
resp_addr_err  out  1  misaligned access
resp_ill_op  out  1  illegal or compiled-out opcode
resp_badvaddr  out  32  req_addr of the erroring request, else 0
ram_addr  out  $clog2(depth)  req_addr[$clog2(depth)+1:2]
ram_din  out  32  lane-positioned write data
ram_dout  in  32  asynchronous read word from data_ram
ram_en  out  1  accept strobe
ram_we  out  4  per-byte write enables

Behaviour:
- FSM states: IDLE and RESP.
  - IDLE to RESP on accept.
  - RESP to IDLE when the response is consumed and no new request is accepted in the same cycle.
  - RESP stays in RESP when the response is consumed and a new request is accepted in the same cycle.
- req_ready = ~reset & (state==IDLE | resp_ready). Full throughput: 1 request per cycle.
- ram_en = accept = req_valid & req_ready. ram_addr and ram_din follow req_* combinationally.
- ram_we is nonzero only when accept=1 and the request is a legal, aligned store.
- Load latency: ram_dout is sampled at the accept edge; resp_valid and the result appear on the following cycle.
- A store is written at its accept edge. A load accepted on the next cycle therefore sees the new data; no forwarding is needed.
- Every accepted request, loads and stores alike, produces exactly one response.
- Response outputs are registered and held stable while resp_valid & ~resp_ready.
- Lane selection, with k = req_addr[1:0] (little-endian):
  - SB: we = 0001<<k; din = {4{wdata[7:0]}}.
  - SH: we = k[1] ? 1100 : 0011; din = {2{wdata[15:0]}}.
  - SW: we = 1111; din = wdata.
  - LB/LBU: byte k, sign-/zero-extended to 32 bits.
  - LH/LHU: halfword k[1], sign-/zero-extended to 32 bits.
  - LW: whole word.
- Alignment errors:
  - LH/LHU/SH with k[0]=1, or LW/SW with k!=0, give resp_addr_err=1 and resp_badvaddr=req_addr.
  - No write occurs and resp_rdata=0.
- Illegal opcode: resp_ill_op=1, no write, resp_rdata=0, resp_badvaddr=0. Alignment is not checked.
- Reset: state IDLE, resp_valid=0, resp_rdata=0, resp_addr_err=0, resp_ill_op=0, resp_badvaddr=0.
  - ram_we=0 and ram_en=0 in every cycle where reset=1.
  - Reset while in RESP discards the pending response.

Optional Feature:
MEM_UNALIGNED_LR_EN
- Defined: LWL/LWR/SWL/SWR are legal and never raise an alignment error.
  - LWL: (mem<<8*(3-k)) | (rt & (32'hFFFFFFFF>>8*(k+1))).
  - LWR: (mem>>8*k) | (rt & ~(32'hFFFFFFFF>>8*k)).
  - SWL: we lanes 0..k; din = wdata>>8*(3-k).
  - SWR: we lanes k..3; din = wdata<<8*k.
- Undefined: these four opcodes are illegal (resp_ill_op=1, no write).

Test Plan:
1. SW addr 0x10, wdata 0xDEADBEEF, then LW addr 0x10 -> SW drives ram_we=1111, ram_addr=4; LW returns resp_rdata=0xDEADBEEF one cycle after its accept.
2. SB addr 0x13, wdata 0xAA -> ram_we=1000, ram_din=0xAAAAAAAA. Then LB 0x13 -> 0xFFFFFFAA; LBU 0x13 -> 0x000000AA; LH 0x12 -> 0xFFFFAAxx, where xx is the existing byte 2.
3. LH addr 0x11 -> ram_we=0, resp_addr_err=1, resp_badvaddr=0x11, resp_rdata=0.
4. resp_ready held low 3 cycles with req_valid=1 -> req_ready=0 and response outputs stable. On release, the next request is accepted in that same cycle, and responses follow back to back.
5. Reset asserted for one cycle while in RESP with a store pending on req_* -> no write; resp_valid=0 and req_ready=1 on the following cycle.
6. With MEM_UNALIGNED_LR_EN, mem[0x20]=0x44332211, rt=0xAABBCCDD -> LWL 0x21 returns 0x2211CCDD; LWR 0x21 returns 0xAA443322; SWR 0x22 gives we=1100, din=0xCCDD0000. Without the macro, LWL gives resp_ill_op=1 and no write.
